// File: rtl/vga_scan_ctrl_if.sv
// vga_scan_ctrl_if -- signal bundle between the VGA scan controller and
// its consumers (DAC/sync pins and the frame-buffer address generator).
//
// Signals:
//   i_en           scan enable, driven by the consumer side
//   o_hsync_n      horizontal sync, active-low
//   o_vsync_n      vertical sync, active-low
//   o_blank_n      DAC blank, high inside the active area
//   o_show_en      coordinates valid for the address generator
//   o_x_cord       active line number
//   o_y_cord       active pixel within the line
//   o_frame_start  one-cycle pulse at pixel (0,0)
//   o_vblank_pulse one-cycle pulse right after the last active pixel
//   o_frame_cnt    frame counter
//
// Modports:
//   master  the scan controller (owns the timing outputs)
//   slave   the consumer (drives the enable, observes the timing)
interface vga_scan_ctrl_if;
  logic       i_en;
  logic       o_hsync_n;
  logic       o_vsync_n;
  logic       o_blank_n;
  logic       o_show_en;
  logic [9:0] o_x_cord;
  logic [9:0] o_y_cord;
  logic       o_frame_start;
  logic       o_vblank_pulse;
  logic [7:0] o_frame_cnt;

  modport master (
    input  i_en,
    output o_hsync_n, o_vsync_n, o_blank_n, o_show_en,
    output o_x_cord, o_y_cord, o_frame_start, o_vblank_pulse, o_frame_cnt
  );

  modport slave (
    output i_en,
    input  o_hsync_n, o_vsync_n, o_blank_n, o_show_en,
    input  o_x_cord, o_y_cord, o_frame_start, o_vblank_pulse, o_frame_cnt
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl -- VGA raster scan timing generator.
//
// A horizontal counter (0..H_TOTAL-1) and a vertical counter
// (0..V_TOTAL-1) walk the raster one pixel per clock while enabled.
// Every output is registered one cycle after the counter state that
// produces it. While the enable is low the counters park at (0,0) and the
// outputs sit at their idle values; the frame counter keeps its value.
//
// Ports:
//   i_clk    pixel clock (single clock domain)
//   i_rst_n  asynchronous active-low reset, released synchronously
//   bus      vga_scan_ctrl_if.master: i_en in, timing/coordinate outputs
//
// Build option:
//   VGA_PIPE_DELAY_EN  when defined, o_hsync_n/o_vsync_n/o_blank_n are
//                      delayed by two extra cycles relative to the
//                      coordinates to line up with memory + RGB decode
//                      latency. Undefined: all outputs share one cycle.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic             i_clk,
  input logic             i_rst_n,
  vga_scan_ctrl_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare value so the sync end bound still fits when a back porch is 0.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG_C   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACTL_C   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG_C   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_r, hcnt_nxt_s;
  logic [VW-1:0] vcnt_r, vcnt_nxt_s;
  logic          active_s, hsync_s, vsync_s, first_px_s, vblank_s;

  logic          hsync_n_r, vsync_n_r, blank_n_r, show_en_r;
  logic [9:0]    x_cord_r, y_cord_r;
  logic          frame_start_r, vblank_pulse_r;
  logic [7:0]    frame_cnt_r;

  // Next raster position and decode of the current position.
  always_comb begin
    hcnt_nxt_s = hcnt_r;
    vcnt_nxt_s = vcnt_r;
    if (hcnt_r == H_LAST_C) begin
      hcnt_nxt_s = {HW{1'b0}};
      if (vcnt_r == V_LAST_C) begin
        vcnt_nxt_s = {VW{1'b0}};
      end else begin
        vcnt_nxt_s = vcnt_r + VW'(1);
      end
    end else begin
      hcnt_nxt_s = hcnt_r + HW'(1);
      vcnt_nxt_s = vcnt_r;
    end

    active_s   = (hcnt_r < H_ACT_C) && (vcnt_r < V_ACT_C);
    hsync_s    = (hcnt_r >= HS_BEG_C) && (hcnt_r < HS_END_C);
    vsync_s    = (vcnt_r >= VS_BEG_C) && (vcnt_r < VS_END_C);
    first_px_s = (hcnt_r == {HW{1'b0}}) && (vcnt_r == {VW{1'b0}});
    // Counter sits one past the last active pixel of the last active line.
    vblank_s   = (hcnt_r == H_ACT_C) && (vcnt_r == V_ACTL_C);
  end

  // Raster counters: advance while enabled, parked at the origin otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt_r <= {HW{1'b0}};
      vcnt_r <= {VW{1'b0}};
    end else if (bus.i_en) begin
      hcnt_r <= hcnt_nxt_s;
      vcnt_r <= vcnt_nxt_s;
    end else begin
      hcnt_r <= {HW{1'b0}};
      vcnt_r <= {VW{1'b0}};
    end
  end

  // Registered timing outputs; the frame counter survives a disable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hsync_n_r      <= 1'b1;
      vsync_n_r      <= 1'b1;
      blank_n_r      <= 1'b0;
      show_en_r      <= 1'b0;
      x_cord_r       <= 10'd0;
      y_cord_r       <= 10'd0;
      frame_start_r  <= 1'b0;
      vblank_pulse_r <= 1'b0;
      frame_cnt_r    <= 8'd0;
    end else if (bus.i_en) begin
      hsync_n_r      <= ~hsync_s;
      vsync_n_r      <= ~vsync_s;
      blank_n_r      <= active_s;
      show_en_r      <= active_s;
      x_cord_r       <= active_s ? 10'(vcnt_r) : 10'd0;
      y_cord_r       <= active_s ? 10'(hcnt_r) : 10'd0;
      frame_start_r  <= first_px_s;
      vblank_pulse_r <= vblank_s;
      frame_cnt_r    <= frame_cnt_r + {7'd0, vblank_s};
    end else begin
      hsync_n_r      <= 1'b1;
      vsync_n_r      <= 1'b1;
      blank_n_r      <= 1'b0;
      show_en_r      <= 1'b0;
      x_cord_r       <= 10'd0;
      y_cord_r       <= 10'd0;
      frame_start_r  <= 1'b0;
      vblank_pulse_r <= 1'b0;
    end
  end

`ifdef VGA_PIPE_DELAY_EN
  // Bit order {hsync_n, vsync_n, blank_n}; idle means syncs high, blanked.
  localparam logic [2:0] SYNC_IDLE_C = 3'b110;
  logic [2:0] sync_d1_r, sync_d2_r;

  // Two-stage delay of the DAC-side strobes, flushed to idle when disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_d1_r <= SYNC_IDLE_C;
      sync_d2_r <= SYNC_IDLE_C;
    end else if (bus.i_en) begin
      sync_d1_r <= {hsync_n_r, vsync_n_r, blank_n_r};
      sync_d2_r <= sync_d1_r;
    end else begin
      sync_d1_r <= SYNC_IDLE_C;
      sync_d2_r <= SYNC_IDLE_C;
    end
  end

  assign bus.o_hsync_n = sync_d2_r[2];
  assign bus.o_vsync_n = sync_d2_r[1];
  assign bus.o_blank_n = sync_d2_r[0];
`else
  assign bus.o_hsync_n = hsync_n_r;
  assign bus.o_vsync_n = vsync_n_r;
  assign bus.o_blank_n = blank_n_r;
`endif

  assign bus.o_show_en      = show_en_r;
  assign bus.o_x_cord       = x_cord_r;
  assign bus.o_y_cord       = y_cord_r;
  assign bus.o_frame_start  = frame_start_r;
  assign bus.o_vblank_pulse = vblank_pulse_r;
  assign bus.o_frame_cnt    = frame_cnt_r;

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, 33, vertical back porch in lines.
REQ-009 SHALL have port i_clk, input, 1, pixel clock (25.175 MHz nominal); the block uses one clock.
REQ-010 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-011 SHALL have port i_en, input, 1, scan enable.
REQ-012 SHALL have port o_hsync_n, output, 1, horizontal sync, active-low.
REQ-013 SHALL have port o_vsync_n, output, 1, vertical sync, active-low.
REQ-014 SHALL have port o_blank_n, output, 1, DAC blank, high in the active area.
REQ-015 SHALL have port o_show_en, output, 1, coordinates valid for the address generator.
REQ-016 SHALL have port o_x_cord, output, 10, active line number, 0..V_ACTIVE-1.
REQ-017 SHALL have port o_y_cord, output, 10, active pixel in line, 0..H_ACTIVE-1.
REQ-018 SHALL have port o_frame_start, output, 1, one-cycle pulse at pixel (0,0).
REQ-019 SHALL have port o_vblank_pulse, output, 1, one-cycle pulse on the first cycle after the last active pixel of a frame.
REQ-020 SHALL have port o_frame_cnt, output, 8, frame counter.

Function
REQ-021 SHALL keep a horizontal counter hcnt in the range 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); hcnt increments every cycle while i_en=1 and wraps to 0.
REQ-022 SHALL keep a vertical counter vcnt in the range 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); vcnt increments only when hcnt wraps, and wraps to 0 after V_TOTAL-1.
REQ-023 SHALL define the active area as hcnt<H_ACTIVE and vcnt<V_ACTIVE; o_show_en=1 and o_blank_n=1 exactly there.
REQ-024 SHALL drive o_x_cord=vcnt and o_y_cord=hcnt in the active area, and 0 outside it.
REQ-025 SHALL assert o_hsync_n=0 for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
REQ-026 SHALL assert o_vsync_n=0 for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, across full lines.
REQ-027 SHALL make all outputs registered; coordinates and o_show_en appear one cycle after the counter state that produces them.
REQ-028 SHALL pulse o_frame_start in the cycle where o_x_cord=0, o_y_cord=0 and o_show_en=1.
REQ-029 SHALL pulse o_vblank_pulse in the cycle after o_x_cord=V_ACTIVE-1 and o_y_cord=H_ACTIVE-1 are presented.
REQ-030 SHALL increment o_frame_cnt together with o_vblank_pulse; it wraps from 255 to 0.
REQ-031 SHALL hold hcnt and vcnt at 0 while i_en=0, with all outputs at their reset values.
REQ-032 SHALL restart scanning from (0,0) when i_en rises, with o_frame_start following one cycle later.
REQ-033 SHALL make o_frame_cnt hold its value while i_en=0; it is not cleared.

Reset
REQ-034 SHALL, while i_rst_n=0, asynchronously clear hcnt, vcnt, o_x_cord, o_y_cord, o_show_en, o_blank_n, o_frame_start, o_vblank_pulse and o_frame_cnt to 0, and set o_hsync_n=1 and o_vsync_n=1.
REQ-035 SHALL release reset synchronously; scanning begins at (0,0) on the first i_clk edge after release with i_en=1.
REQ-036 SHALL abandon any partial frame when reset is asserted mid-frame, with no sync glitch low.

Configuration
REQ-037 SHALL, with VGA_PIPE_DELAY_EN defined, delay o_hsync_n, o_vsync_n and o_blank_n by 2 extra cycles relative to the coordinates; this matches the 2-cycle memory and RGB decode latency. The delay registers reset to inactive values.
REQ-038 SHALL, without VGA_PIPE_DELAY_EN, align all outputs to the same cycle as the coordinates.

Verification
REQ-039 SHALL cover: reset release with i_en=1 -> o_frame_start 1 cycle later with x=0,y=0; next pulse exactly 420000 cycles later.
REQ-040 SHALL cover: one line -> o_show_en high for 640 cycles, o_hsync_n low for 96 cycles starting 656 cycles after y=0.
REQ-041 SHALL cover: one frame -> o_vsync_n low for 1600 cycles (2 lines) starting at line 490; o_vblank_pulse once, after (479,639).
REQ-042 SHALL cover: 256 frames -> o_frame_cnt wraps 255->0 on the 256th o_vblank_pulse.
REQ-043 SHALL cover: i_en dropped at (100,300) then raised -> outputs idle while low; scan resumes at (0,0) and o_frame_cnt is unchanged.
REQ-044 SHALL cover: VGA_PIPE_DELAY_EN defined -> o_blank_n rises 2 cycles after o_show_en; both fall 640 cycles after rising.
